// File: rtl/mul_scan_ctrl_if.sv
// Operand/display bus of the 2x2 multiplier scanner.
// The scanner drives it through the slave modport; the stimulus side uses master.
interface mul_scan_ctrl_if;
    logic       run;
    logic       step;
    logic [3:0] pair;
    logic [3:0] prod;
    logic [3:0] an;
    logic [6:0] s;
    logic       dp;

    modport master (output run, step, input pair, prod, an, s, dp);
    modport slave  (input run, step, output pair, prod, an, s, dp);
endinterface

// File: rtl/mul_scan_ctrl.sv
// Operand sequencer and 4-digit 7-segment scanner for the 2x2-bit multiplier.
// Define MULSCAN_BLANK_EN to insert a 1-clk all-off cycle at the start of every digit slot.
module mul_scan_ctrl #(
    parameter int SCAN_DIV     = 16,
    parameter int DWELL_FRAMES = 64
) (
    input  logic           clk,
    input  logic           reset,
    mul_scan_ctrl_if.slave bus
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(DWELL_FRAMES - 1);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    pair;
    logic          step_q;
    logic          load;
    logic [3:0]    an;
    logic [6:0]    s;

    logic          scan_wrap, frame_tick, frame_wrap, adv;
    logic [1:0]    x, y;
    logic [3:0]    prod;
    logic [3:0]    digit_val;
    logic          digit_blank;
    logic [3:0]    an_next;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1110111;
            4'd1:    seg7 = 7'b0010010;
            4'd2:    seg7 = 7'b1011101;
            4'd3:    seg7 = 7'b1011011;
            4'd4:    seg7 = 7'b0111010;
            4'd5:    seg7 = 7'b1101011;
            4'd6:    seg7 = 7'b1101111;
            4'd7:    seg7 = 7'b1010010;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    assign x    = pair[3:2];
    assign y    = pair[1:0];
    assign prod = {2'b00, x} * {2'b00, y};

    assign scan_wrap  = (scan_cnt == SCAN_LAST);
    assign frame_tick = scan_wrap && (idx == 2'd3);
    assign frame_wrap = frame_tick && (frame_cnt == FRAME_LAST);
    // run selects exactly one advance source, so both can never add at once
    assign adv = bus.run ? frame_wrap : (bus.step & ~step_q);

    always_comb begin
        digit_val   = prod;
        digit_blank = 1'b0;
        case (idx)
            2'd0: digit_val = prod;
            2'd1: digit_blank = 1'b1;
            2'd2: digit_val = {2'b00, y};
            2'd3: digit_val = {2'b00, x};
            default: digit_val = prod;
        endcase
    end

    assign an_next = ~(4'b0001 << idx);

    // load marks the first clk of a slot: the display latches idx/pair as they stand then
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            idx       <= 2'd0;
            frame_cnt <= '0;
            pair      <= 4'd0;
            step_q    <= 1'b0;
            load      <= 1'b1;
            an        <= 4'b1111;
            s         <= 7'b0;
        end else begin
            step_q   <= bus.step;
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap)
                idx <= idx + 2'd1;
            if (frame_tick)
                frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
            if (adv)
                pair <= pair + 4'd1;
            load <= scan_wrap;
            if (load) begin
                an <= an_next;
                s  <= digit_blank ? 7'b0 : seg7(digit_val);
            end
`ifdef MULSCAN_BLANK_EN
            else if (scan_wrap) begin
                an <= 4'b1111;
                s  <= 7'b0;
            end
`else
`endif
        end
    end

    assign bus.pair = pair;
    assign bus.prod = prod;
    assign bus.an   = an;
    assign bus.s    = s;
    assign bus.dp   = 1'b1;
endmodule
